// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption round sequencer.
package aes_ctrl_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_NUM_COLS   = 4;
  localparam int AES_ROUND_W    = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_KEYWAIT  = 4'd2,
    ST_ARK      = 4'd3,
    ST_ISR      = 4'd4,
    ST_ISB_WAIT = 4'd5,
    ST_ISB_LOAD = 4'd6,
    ST_IMC      = 4'd7,
    ST_DONE     = 4'd8
  } aes_ctrl_state_t;

  // States whose cycle commits a datapath result (and can be held in debug mode).
  function automatic logic is_load_state(aes_ctrl_state_t s);
    return (s == ST_ARK) || (s == ST_ISR) || (s == ST_ISB_LOAD) || (s == ST_IMC);
  endfunction

endpackage

// File: rtl/aes_step_pulse.sv
// Two-flop synchronizer plus rising-edge one-shot for the asynchronous step button.
module aes_step_pulse (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic step_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= step_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM sequencing the shared AES-128 decryption datapath through one inverse cipher.
//
// state       | meaning
// ST_IDLE     | waiting for AES_START, all outputs low
// ST_INIT     | load message and key into the datapath
// ST_KEYWAIT  | key schedule settling (KEYEXP_WAIT cycles)
// ST_ARK      | AddRoundKey with the current round key
// ST_ISR      | InvShiftRows
// ST_ISB_WAIT | InvSubBytes ROM read in flight (SUBBYTE_LAT cycles)
// ST_ISB_LOAD | InvSubBytes ROM data valid, commit
// ST_IMC      | InvMixColumns, one column per cycle
// ST_DONE     | plaintext in State, wait for AES_START low
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEYEXP_WAIT = 12,
  parameter int unsigned SUBBYTE_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  input  logic       AES_DEBUG,
  input  logic       AES_STEP,
  output logic       AES_DONE,
  output logic       Initialization_En,
  output logic       AddKey_En,
  output logic       ShiftRow_En,
  output logic       SubByte_En,
  output logic       MixColumn_En,
  output logic       SubByte_Read,
  output logic       Load_En,
  output logic [3:0] Round,
  output logic [1:0] Column
);

  localparam int unsigned WAIT_MAX = (KEYEXP_WAIT > SUBBYTE_LAT) ? KEYEXP_WAIT : SUBBYTE_LAT;
  localparam int          WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0]      KEYWAIT_LOAD = WAIT_W'(KEYEXP_WAIT - 1);
  localparam logic [WAIT_W-1:0]      ISBWAIT_LOAD = WAIT_W'(SUBBYTE_LAT - 1);
  localparam logic [AES_ROUND_W-1:0] LAST_ROUND   = AES_ROUND_W'(AES_NUM_ROUNDS);
  localparam logic [1:0]             LAST_COL     = 2'(AES_NUM_COLS - 1);

  aes_ctrl_state_t        state_q, state_d;
  logic                   hold_q, hold_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [AES_ROUND_W-1:0] round_q, round_d;
  logic [1:0]             col_q, col_d;

  logic step_pulse;
  logic hold_release;

  logic init_q, addkey_q, shiftrow_q, subbyte_q, mixcol_q, subread_q, load_q, done_q;

  aes_step_pulse u_step (
    .clk_i   (CLK),
    .rst_n_i (RESET),
    .step_i  (AES_STEP),
    .pulse_o (step_pulse)
  );

  // Dropping debug while parked releases the hold so the sequencer cannot deadlock.
  assign hold_release = step_pulse | ~AES_DEBUG;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    round_d = round_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: begin
        round_d = '0;
        col_d   = '0;
        hold_d  = 1'b0;
        if (AES_START) state_d = ST_INIT;
      end
      ST_INIT: begin
        round_d = '0;
        col_d   = '0;
        wait_d  = KEYWAIT_LOAD;
        state_d = ST_KEYWAIT;
      end
      ST_KEYWAIT: begin
        if (wait_q == '0) begin
          state_d = ST_ARK;
          hold_d  = AES_DEBUG;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_ARK: begin
        if (hold_q) begin
          if (hold_release) hold_d = 1'b0;
        end else if (round_q == '0) begin
          state_d = ST_ISR;
          round_d = round_q + AES_ROUND_W'(1);
          hold_d  = AES_DEBUG;
        end else if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IMC;
          col_d   = '0;
          hold_d  = AES_DEBUG;
        end
      end
      ST_ISR: begin
        if (hold_q) begin
          if (hold_release) hold_d = 1'b0;
        end else begin
          state_d = ST_ISB_WAIT;
          wait_d  = ISBWAIT_LOAD;
        end
      end
      ST_ISB_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_ISB_LOAD;
          hold_d  = AES_DEBUG;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_ISB_LOAD: begin
        if (hold_q) begin
          if (hold_release) hold_d = 1'b0;
        end else begin
          state_d = ST_ARK;
          hold_d  = AES_DEBUG;
        end
      end
      ST_IMC: begin
        if (hold_q) begin
          if (hold_release) hold_d = 1'b0;
        end else if (col_q == LAST_COL) begin
          state_d = ST_ISR;
          col_d   = '0;
          round_d = round_q + AES_ROUND_W'(1);
          hold_d  = AES_DEBUG;
        end else begin
          col_d  = col_q + 2'd1;
          hold_d = AES_DEBUG;
        end
      end
      ST_DONE: begin
        hold_d = 1'b0;
        if (!AES_START) begin
          state_d = ST_IDLE;
          round_d = '0;
          col_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 1'b0;
        round_d = '0;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      hold_q  <= 1'b0;
      wait_q  <= '0;
      round_q <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      init_q     <= 1'b0;
      addkey_q   <= 1'b0;
      shiftrow_q <= 1'b0;
      subbyte_q  <= 1'b0;
      mixcol_q   <= 1'b0;
      subread_q  <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      init_q     <= (state_d == ST_INIT);
      addkey_q   <= (state_d == ST_ARK);
      shiftrow_q <= (state_d == ST_ISR);
      subbyte_q  <= (state_d == ST_ISB_WAIT) || (state_d == ST_ISB_LOAD);
      mixcol_q   <= (state_d == ST_IMC);
      subread_q  <= (state_d == ST_ISB_LOAD);
      load_q     <= is_load_state(state_d) && !hold_d;
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign Initialization_En = init_q;
  assign AddKey_En         = addkey_q;
  assign ShiftRow_En       = shiftrow_q;
  assign SubByte_En        = subbyte_q;
  assign MixColumn_En      = mixcol_q;
  assign SubByte_Read      = subread_q;
  assign Load_En           = load_q;
  assign AES_DONE          = done_q;
  assign Round             = round_q;
  assign Column            = col_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer against a phase-list model of the decryption.
module tb_aes_round_sequencer;

  localparam int OP_NONE = 0;
  localparam int OP_INIT = 1;
  localparam int OP_ARK  = 2;
  localparam int OP_ISR  = 3;
  localparam int OP_ISBW = 4;
  localparam int OP_ISBL = 5;
  localparam int OP_IMC  = 6;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic AES_START = 1'b0;
  logic AES_DEBUG = 1'b0;
  logic AES_STEP = 1'b0;

  logic AES_DONE, Initialization_En, AddKey_En, ShiftRow_En, SubByte_En;
  logic MixColumn_En, SubByte_Read, Load_En;
  logic [3:0] Round;
  logic [1:0] Column;

  logic AES_DONE2, Initialization_En2, AddKey_En2, ShiftRow_En2, SubByte_En2;
  logic MixColumn_En2, SubByte_Read2, Load_En2;
  logic [3:0] Round2;
  logic [1:0] Column2;

  logic [13:0] act, act2;
  logic [13:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  aes_round_sequencer dut (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DEBUG(AES_DEBUG),
    .AES_STEP(AES_STEP), .AES_DONE(AES_DONE), .Initialization_En(Initialization_En),
    .AddKey_En(AddKey_En), .ShiftRow_En(ShiftRow_En), .SubByte_En(SubByte_En),
    .MixColumn_En(MixColumn_En), .SubByte_Read(SubByte_Read), .Load_En(Load_En),
    .Round(Round), .Column(Column)
  );

  aes_round_sequencer #(.KEYEXP_WAIT(12), .SUBBYTE_LAT(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_DEBUG(AES_DEBUG),
    .AES_STEP(AES_STEP), .AES_DONE(AES_DONE2), .Initialization_En(Initialization_En2),
    .AddKey_En(AddKey_En2), .ShiftRow_En(ShiftRow_En2), .SubByte_En(SubByte_En2),
    .MixColumn_En(MixColumn_En2), .SubByte_Read(SubByte_Read2), .Load_En(Load_En2),
    .Round(Round2), .Column(Column2)
  );

  assign act  = {Initialization_En, AddKey_En, ShiftRow_En, SubByte_En, SubByte_Read,
                 MixColumn_En, Load_En, AES_DONE, Round, Column};
  assign act2 = {Initialization_En2, AddKey_En2, ShiftRow_En2, SubByte_En2, SubByte_Read2,
                 MixColumn_En2, Load_En2, AES_DONE2, Round2, Column2};

  // Expected output word for one cycle of a given operation.
  function automatic logic [13:0] ev(int op, int rnd, int col, bit ld);
    logic [7:0] f;
    logic [3:0] r4;
    logic [1:0] c2;
    f  = '0;
    r4 = rnd[3:0];
    c2 = col[1:0];
    case (op)
      OP_INIT: f[7] = 1'b1;
      OP_ARK:  f[6] = 1'b1;
      OP_ISR:  f[5] = 1'b1;
      OP_ISBW: f[4] = 1'b1;
      OP_ISBL: begin f[4] = 1'b1; f[3] = 1'b1; end
      OP_IMC:  f[2] = 1'b1;
      default: ;
    endcase
    f[1] = ld;
    return {f, r4, c2};
  endfunction

  // Cycle-by-cycle sequence from INIT up to (not including) DONE.
  task automatic build_trace(int k, int l);
    exp_q.delete();
    exp_q.push_back(ev(OP_INIT, 0, 0, 1'b0));
    repeat (k) exp_q.push_back(ev(OP_NONE, 0, 0, 1'b0));
    exp_q.push_back(ev(OP_ARK, 0, 0, 1'b1));
    for (int r = 1; r <= 10; r++) begin
      exp_q.push_back(ev(OP_ISR, r, 0, 1'b1));
      repeat (l) exp_q.push_back(ev(OP_ISBW, r, 0, 1'b0));
      exp_q.push_back(ev(OP_ISBL, r, 0, 1'b1));
      exp_q.push_back(ev(OP_ARK, r, 0, 1'b1));
      if (r < 10)
        for (int c = 0; c < 4; c++) exp_q.push_back(ev(OP_IMC, r, c, 1'b1));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    AES_START = 1'b0;
    AES_DEBUG = 1'b0;
    AES_STEP  = 1'b0;
    RESET     = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    repeat (2) tick();
    checks++;
    if (act !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", act, 14'h0);
    end
    checks++;
    if (act2 !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs_lat2 got=%h exp=%h", act2, 14'h0);
    end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int loads = 0;
    int rseq[$];
    int done_at = -1;
    int done_at2 = -1;
    int bad_rounds = 0;
    do_reset();
    build_trace(12, 1);
    AES_START = 1'b1;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (i < exp_q.size()) begin
        checks++;
        if (act !== exp_q[i]) begin
          errors++;
          $display("FAIL trace_cycle_%0d got=%h exp=%h", i, act, exp_q[i]);
        end
      end
      if (Load_En && done_at < 0) loads++;
      if (AddKey_En && Load_En && done_at < 0) rseq.push_back(int'(Round));
      if (AES_DONE && done_at < 0) done_at = i;
      if (AES_DONE2 && done_at2 < 0) done_at2 = i;
      if (done_at >= 0 && done_at2 >= 0) break;
    end
    checks++;
    if (done_at != 90) begin
      errors++;
      $display("FAIL done_latency got=%0d exp=%0d", done_at, 90);
    end
    checks++;
    if (done_at2 != 100) begin
      errors++;
      $display("FAIL done_latency_lat2 got=%0d exp=%0d", done_at2, 100);
    end
    checks++;
    if (loads != 11 + 10 + 10 + 9 * 4) begin
      errors++;
      $display("FAIL load_count got=%0d exp=%0d", loads, 11 + 10 + 10 + 9 * 4);
    end
    foreach (rseq[j]) if (rseq[j] != j) bad_rounds++;
    checks++;
    if (rseq.size() != 11 || bad_rounds != 0) begin
      errors++;
      $display("FAIL ark_round_seq got_len=%0d bad=%0d exp_len=11 bad=0", rseq.size(), bad_rounds);
    end
    AES_START = 1'b0;
    tick();
    checks++;
    if (act !== 14'h0 || act2 !== 14'h0) begin
      errors++;
      $display("FAIL idle_after_done got=%h/%h exp=0", act, act2);
    end
  endtask

  task automatic test_debug();
    logic [13:0] ldq[$];
    int stray = 0;
    do_reset();
    build_trace(12, 1);
    foreach (exp_q[i]) if (exp_q[i][7]) ldq.push_back(exp_q[i]);
    AES_DEBUG = 1'b1;
    AES_START = 1'b1;
    // A press during KEYWAIT must be discarded.
    for (int i = 0; i <= 20; i++) begin
      tick();
      if (i == 1) AES_STEP = 1'b1;
      if (i == 4) AES_STEP = 1'b0;
      if (Load_En) stray++;
    end
    checks++;
    if (stray != 0 || act !== ev(OP_ARK, 0, 0, 1'b0)) begin
      errors++;
      $display("FAIL debug_keywait_press loads=%0d state=%h exp loads=0 state=%h",
               stray, act, ev(OP_ARK, 0, 0, 1'b0));
    end
    for (int n = 0; n < ldq.size(); n++) begin
      int gap = 10 + int'($urandom_range(0, 3));
      int got = 0;
      int at = -1;
      logic [13:0] seen = '0;
      AES_STEP = 1'b1;
      for (int c = 1; c <= gap; c++) begin
        tick();
        if (c == 4) AES_STEP = 1'b0;
        if (Load_En) begin
          got++;
          if (at < 0) begin
            at = c;
            seen = act;
          end
        end
      end
      checks++;
      if (got != 1 || at != 3) begin
        errors++;
        $display("FAIL debug_press_%0d loads=%0d at=%0d exp loads=1 at=3", n, got, at);
      end
      checks++;
      if (seen !== ldq[n]) begin
        errors++;
        $display("FAIL debug_load_%0d got=%h exp=%h", n, seen, ldq[n]);
      end
    end
    checks++;
    if (AES_DONE !== 1'b1 || AES_DONE2 !== 1'b1) begin
      errors++;
      $display("FAIL debug_done got=%b/%b exp=1/1", AES_DONE, AES_DONE2);
    end
    AES_DEBUG = 1'b0;
    AES_START = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int done_at = -1;
    do_reset();
    AES_START = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (MixColumn_En && Round == 4'd5 && Column == 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach got=timeout exp=round5_col2");
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (act !== 14'h0 || act2 !== 14'h0) begin
      errors++;
      $display("FAIL reset_async_clear got=%h/%h exp=0", act, act2);
    end
    repeat (2) tick();
    RESET = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (AES_DONE) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (done_at != 90) begin
      errors++;
      $display("FAIL reset_rerun_latency got=%0d exp=%0d", done_at, 90);
    end
  endtask

  task automatic test_start_protocol();
    int drop = int'($urandom_range(3, 60));
    int done_at = -1;
    int high_cnt = 0;
    do_reset();
    AES_START = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == drop) AES_START = 1'b0;
      if (AES_DONE) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (done_at != 90) begin
      errors++;
      $display("FAIL start_drop_latency drop=%0d got=%0d exp=%0d", drop, done_at, 90);
    end
    tick();
    checks++;
    if (act !== 14'h0) begin
      errors++;
      $display("FAIL start_drop_idle got=%h exp=%h", act, 14'h0);
    end

    do_reset();
    AES_START = 1'b1;
    done_at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (AES_DONE) begin
        done_at = i;
        break;
      end
    end
    checks++;
    if (done_at != 90) begin
      errors++;
      $display("FAIL start_held_latency got=%0d exp=%0d", done_at, 90);
    end
    repeat (50) begin
      tick();
      if (AES_DONE) high_cnt++;
    end
    checks++;
    if (high_cnt != 50) begin
      errors++;
      $display("FAIL done_hold got=%0d exp=%0d", high_cnt, 50);
    end
    AES_START = 1'b0;
    tick();
    checks++;
    if (act !== 14'h0) begin
      errors++;
      $display("FAIL done_to_idle got=%h exp=%h", act, 14'h0);
    end
    AES_START = 1'b1;
    tick();
    checks++;
    if (act !== ev(OP_INIT, 0, 0, 1'b0)) begin
      errors++;
      $display("FAIL restart_init got=%h exp=%h", act, ev(OP_INIT, 0, 0, 1'b0));
    end
    AES_START = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_debug();
    test_reset_mid();
    test_start_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
